// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame-length and parity encodings.
// Used by both the transmit (TSR) and receive (RSR) shift registers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Data bits per character for a 2-bit length code (5..8).
  function automatic logic [3:0] len_to_bits(input logic [1:0] rlen);
    return 4'(rlen) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronizer for the asynchronous serial input. With RSR_MAJORITY_VOTE_EN
// defined it also produces a 2-of-3 vote over the last three btick samples.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef RSR_MAJORITY_VOTE_EN
  input  logic btick,
`endif
  input  logic rx_in,
  output logic rx_s,
  output logic rx_smp
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: flops preset to 1 so reset looks like an idle line, not a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RSR_MAJORITY_VOTE_EN
  // hist_q[0] holds the sample from the previous btick, hist_q[1] the one before.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (btick) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign rx_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign rx_smp = rx_s;
`endif

endmodule

// File: rtl/uart_rsr.sv
// UART receive shift register: oversampled deframing of start/data/parity/stop,
// pushing characters with error flags to the RX FIFO. Option: RSR_MAJORITY_VOTE_EN.
module uart_rsr
  import uart_pkg::*;
#(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btick,
  input  logic       rx_in,
  input  logic [1:0] rlen,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [7:0] rdata,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int TW = $clog2(OSR);

  // With voting the start decision moves one btick later; all later sample
  // points stay OSR apart from it, so they land on mid+1 automatically.
`ifdef RSR_MAJORITY_VOTE_EN
  localparam logic [TW-1:0] START_LAST = TW'(OSR / 2);
`else
  localparam logic [TW-1:0] START_LAST = TW'(OSR / 2 - 1);
`endif
  localparam logic [TW-1:0] BIT_LAST = TW'(OSR - 1);

  rx_state_e   state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]  bit_cnt;
  logic [3:0]  len_q;
  logic        par_en_q;
  logic        par_type_q;
  logic        par_bad;
  logic [7:0]  shreg;
  logic        rx_s;
  logic        rx_smp;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
`ifdef RSR_MAJORITY_VOTE_EN
    .btick (btick),
`endif
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .rx_smp(rx_smp)
  );

  // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_type_q  <= 1'b0;
      par_bad     <= 1'b0;
      shreg       <= '0;
      rdata       <= '0;
      wr_en       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      if (btick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state      <= START;
              tick_cnt   <= '0;
              bit_cnt    <= '0;
              shreg      <= '0;
              par_bad    <= 1'b0;
              len_q      <= len_to_bits(rlen);
              par_en_q   <= parity_en;
              par_type_q <= parity_type;
            end
          end

          START: begin
            if (tick_cnt == START_LAST) begin
              tick_cnt <= '0;
              state    <= rx_smp ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt            <= '0;
              shreg[bit_cnt[2:0]] <= rx_smp;
              bit_cnt             <= bit_cnt + 4'd1;
              if (bit_cnt == len_q - 4'd1) begin
                state <= par_en_q ? PARITY : STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          PARITY: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_bad  <= ((^shreg) ^ rx_smp) != par_type_q;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt    <= '0;
              wr_en       <= !fifo_full;
              overrun_err <= fifo_full;
              frame_err   <= !rx_smp;
              parity_err  <= par_bad;
              if (!fifo_full) begin
                rdata <= shreg;
              end
              // A low stop bit is treated as a possible break: wait for release.
              state <= rx_smp ? IDLE : BRK_WAIT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          BRK_WAIT: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rsr.sv
// Scoreboard bench for uart_rsr: directed frames push expected completions,
// a negedge monitor pops and compares whenever the DUT reports a completion.
module tb_uart_rsr;
  import uart_pkg::*;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       btick = 1'b0;
  logic       rx_in;
  logic [1:0] rlen;
  logic       parity_en;
  logic       parity_type;
  logic       fifo_full;
  logic       wr_en;
  logic [7:0] rdata;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       wr;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   bdiv = 0;

  uart_rsr #(
    .OSR(OSR),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btick      (btick),
    .rx_in      (rx_in),
    .rlen       (rlen),
    .parity_en  (parity_en),
    .parity_type(parity_type),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .rdata      (rdata),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // btick: one clk high every three clks, changed on the falling edge.
  always @(negedge clk) begin
    if (bdiv == 2) begin
      bdiv  = 0;
      btick = 1'b1;
    end else begin
      bdiv  = bdiv + 1;
      btick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && (wr_en || parity_err || frame_err || overrun_err)) begin
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_en", 32'(wr_en), 32'(mon_e.wr));
        check("rdata", 32'(rdata), 32'(mon_e.data));
        check("parity_err", 32'(parity_err), 32'(mon_e.pe));
        check("frame_err", 32'(frame_err), 32'(mon_e.fe));
        check("overrun_err", 32'(overrun_err), 32'(mon_e.ov));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!btick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic ptype, input logic pbit, input logic stopv,
                            input exp_t e);
    rlen        = 2'(nbits - 5);
    parity_en   = pen;
    parity_type = ptype;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stopv);
    if (stopv) begin
      send_bit(1'b1);
      check("busy_after_frame", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    rx_in       = 1'b1;
    rlen        = LEN_8;
    parity_en   = 1'b0;
    parity_type = PAR_EVEN;
    fifo_full   = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    rst = 1'b0;
    wait_ticks(OSR);

    // 8N1 0xEB
    send_frame(8'hEB, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, '{1'b1, 8'hEB, 1'b0, 1'b0, 1'b0});
    // 7N1 0x6B, then 5N1 0x1A
    send_frame(8'h6B, 7, 1'b0, PAR_EVEN, 1'b0, 1'b1, '{1'b1, 8'h6B, 1'b0, 1'b0, 1'b0});
    send_frame(8'h1A, 5, 1'b0, PAR_EVEN, 1'b0, 1'b1, '{1'b1, 8'h1A, 1'b0, 1'b0, 1'b0});
    // 8O1 0xA5 (four ones): parity bit 1 is correct, 0 is a parity error
    send_frame(8'hA5, 8, 1'b1, PAR_ODD, 1'b1, 1'b1, '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
    // 8E1 0x07 (three ones): parity bit 1 is correct for even
    send_frame(8'h07, 8, 1'b1, PAR_EVEN, 1'b1, 1'b1, '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0});

    // 8N1 0x55 with a low stop bit, line then held low for three more bit times
    send_frame(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0});
    repeat (3) send_bit(1'b0);
    check("busy_in_break", 32'(busy), 32'd1);
    send_bit(1'b1);
    check("busy_after_break", 32'(busy), 32'd0);

    // Start glitch: low for 4 bticks only
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(2 * OSR);
    check("busy_after_glitch", 32'(busy), 32'd0);

    // Reset in the middle of the data bits
    rlen      = LEN_8;
    parity_en = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("busy_mid_data", 32'(busy), 32'd1);
    rst   = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    rst = 1'b0;
    send_bit(1'b1);
    send_frame(8'h3C, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0});

    // Overrun: FIFO full during completion of 0x81, rdata keeps 0x3C
    fifo_full = 1'b1;
    send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1});
    fifo_full = 1'b0;
    check("rdata_after_overrun", 32'(rdata), 32'h3C);

    wait_ticks(2 * OSR);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rsr.md
Name: uart_rsr

Overview:
UART receive shift register, the receive-side counterpart of the TSR transmit path.
- Oversamples the serial line on the shared baud tick and deframes start/data/parity/stop.
- Pushes each received character into the RX FIFO with per-frame error flags.
- Frame format is set by the same control fields as the transmitter: length 5-8 bits, optional even/odd parity, 1 stop bit.

Parameters:
OSR, 16, btick pulses per bit period (even, >=8)
SYNC_STAGES, 2, synchronizer flops on rx_in (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
btick  input  1  one-clk pulse, OSR per bit period
rx_in  input  1  serial line, idle high, asynchronous
rlen  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits
parity_en  input  1  1 = parity bit present after data
parity_type  input  1  0 = even, 1 = odd
fifo_full  input  1  RX FIFO cannot accept a write
wr_en  output  1  one-clk push strobe to RX FIFO
rdata  output  8  received character, LSB-first assembled, unused MSBs zero
parity_err  output  1  one-clk pulse with frame completion
frame_err  output  1  one-clk pulse, stop bit sampled low
overrun_err  output  1  one-clk pulse, frame completed while fifo_full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; synchronizer flops set to 1; all outputs 0; counters 0. Reset mid-frame discards the partial character.
- rx_in passes through SYNC_STAGES flops; all decisions use the synchronized rx_s. All state changes happen only on clk edges with btick=1, except output pulse clearing.
- tick_cnt counts btick within a bit; bit_cnt counts data bits; rlen, parity_en and parity_type are latched at the start-bit edge and held for the frame.
- IDLE: rx_s=0 -> START, tick_cnt=0.
- START: at tick_cnt=OSR/2-1, sample rx_s.
  - 0 -> DATA, tick_cnt=0.
  - 1 -> glitch, back to IDLE, no flags.
- DATA: at tick_cnt=OSR-1 (mid-bit), shift rx_s into bit position bit_cnt.
  - After N=rlen+5 bits -> PARITY if parity_en, else STOP.
- PARITY: at mid-bit, sample p. parity_err = (^data ^ p) != parity_type.
- STOP: at mid-bit, sample stop. Completion pulses assert in the next clk:
  - rdata updates.
  - wr_en=1 if !fifo_full.
  - overrun_err=1 if fifo_full; data is dropped and rdata is not updated.
  - frame_err=1 if stop=0; data is still written.
  - parity_err as computed.
  - Next state: stop=1 -> IDLE; stop=0 -> BRK_WAIT.
- BRK_WAIT: stay until rx_s=1 (line released), then IDLE. Prevents a break being read as repeated 0x00 frames.
- Latency: wr_en asserts exactly 1 clk after the btick that samples the stop bit. A new start edge is accepted on the following btick.
- All pulses are exactly 1 clk wide. busy is low only in IDLE.
- btick and fifo_full changing in the same cycle: the fifo_full value in the completion cycle governs.

Optional Feature:
RSR_MAJORITY_VOTE_EN
- Defined: each sample point (start confirm, data, parity, stop) takes 2-of-3 majority of rx_s at tick_cnt = mid-1, mid, mid+1. The decision is taken at mid+1, adding 1 btick of latency per frame end.
- Undefined: single sample at mid; no vote logic synthesized.

Decomposition:
- Shared package uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
  - Length encoding constants LEN_5..LEN_8, PAR_EVEN=0, PAR_ODD=1.
  - Function len_to_bits(rlen). The TSR uses the same package.
- One sub-module is natural: uart_rx_sync, the parameterized SYNC_STAGES synchronizer, with optional 3-sample vote under the macro.

Test Plan:
- 8N1, rlen=11, serialize 0xEB at OSR=16 -> single wr_en, rdata=0xEB, all error pulses 0, busy low after stop.
- 7N1 with 0x6B, then 5N1 with 0x1A -> rdata=0x6B then 0x1A, upper bits zero.
- 8O1 0xA5 with correct parity bit 1 -> parity_err=0. Repeat with parity bit 0 -> parity_err=1 and wr_en=1.
- 8N1 0x55 with stop forced 0, line held low 3 bit times -> frame_err=1 once, state stays in BRK_WAIT until rx_in=1, no further wr_en.
- Start glitch: rx_in low for 4 bticks -> no wr_en, returns to IDLE. Also assert rst mid-DATA -> outputs 0, IDLE, next frame 0x3C received correctly.
- fifo_full=1 during the completion of 0x81 -> wr_en=0, overrun_err=1, rdata keeps its previous value.
